// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR scrub controller and its per-lane voter.
package tmr_pkg;

  localparam int LANES_DEF  = 8;
  localparam int LANE_W_DEF = 16;

  localparam logic [1:0] FAULT_NONE = 2'd3;

  typedef enum logic [1:0] {MONITOR, CONFIRM, RECOVER, SETTLE} state_e;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic logic [2:0] rep_onehot(input logic [1:0] id);
    return (id == FAULT_NONE) ? 3'b000 : (3'b001 << id);
  endfunction

endpackage

// File: rtl/tmr_lane_vote.sv
// One-lane 2-of-3 voter with a replica exclude mask.
// With one replica excluded, nomaj_o reports that the remaining healthy pair disagrees.
module tmr_lane_vote
  import tmr_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [LANE_W-1:0] c_i,
  input  logic [2:0]        excl_i,
  output logic [LANE_W-1:0] vote_o,
  output logic [2:0]        outvoted_o,
  output logic              nomaj_o
);

  logic e01, e02, e12;

  always_comb begin
    e01        = (a_i == b_i);
    e02        = (a_i == c_i);
    e12        = (b_i == c_i);
    vote_o     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    outvoted_o = 3'b000;
    nomaj_o    = 1'b0;
    case (excl_i)
      3'b001: begin vote_o = b_i; nomaj_o = !e12; end
      3'b010: begin vote_o = a_i; nomaj_o = !e02; end
      3'b100: begin vote_o = a_i; nomaj_o = !e01; end
      default: begin
        outvoted_o = {e01 & !e02, e02 & !e01, e12 & !e01};
        nomaj_o    = !e01 && !e02 && !e12;
        // No two replicas agree: pass replica 0 rather than a bitwise blend.
        if (nomaj_o) vote_o = a_i;
      end
    endcase
  end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// TMR supervisor: per-lane voting, outvoted-replica confirm/resync sequencing, fault stats.
// Optional TMR_ERR_INJECT_EN adds a single-bit error injection port set ahead of voting.
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int LANES       = LANES_DEF,
  parameter int LANE_W      = LANE_W_DEF,
  parameter int CONFIRM_CYC = 2,
  parameter int RECOVER_CYC = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [LANES-1:0][LANE_W-1:0] y0,
  input  logic [LANES-1:0][LANE_W-1:0] y1,
  input  logic [LANES-1:0][LANE_W-1:0] y2,
`ifdef TMR_ERR_INJECT_EN
  input  logic                         inj_en,
  input  logic [1:0]                   inj_rep,
  input  logic [lane_idx_w(LANES)-1:0] inj_lane,
`endif
  output logic [LANES-1:0][LANE_W-1:0] y_vote,
  output logic [2:0]                   rep_reset,
  output logic [1:0]                   fault_id,
  output logic [CNT_W-1:0]             fault_cnt0,
  output logic [CNT_W-1:0]             fault_cnt1,
  output logic [CNT_W-1:0]             fault_cnt2,
  output logic                         busy,
  output logic                         unrecoverable
);

  logic [LANES-1:0][LANE_W-1:0] yr [3];
  logic [LANES-1:0][LANE_W-1:0] lane_vote, vote_q;
  logic [LANES-1:0][2:0]        lane_ov;
  logic [LANES-1:0]             lane_nomaj;
  logic [2:0]                   excl, ov_any;
  logic                         nomaj_any, single, multi, rec_entry;
  logic [1:0]                   cand_id;

  state_e                  state_q, state_d;
  logic [1:0]              fault_id_q, fault_id_d;
  logic [7:0]              seq_q, seq_d;
  logic [2:0][CNT_W-1:0]   fcnt_q, fcnt_d;
  logic                    unrec_q, unrec_d;

  always_comb begin
    yr[0] = y0;
    yr[1] = y1;
    yr[2] = y2;
`ifdef TMR_ERR_INJECT_EN
    if (inj_en && inj_rep != FAULT_NONE)
      yr[inj_rep][inj_lane][0] = ~yr[inj_rep][inj_lane][0];
`endif
  end

  assign excl = (state_q == RECOVER || state_q == SETTLE) ? rep_onehot(fault_id_q) : 3'b000;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tmr_lane_vote #(.LANE_W(LANE_W)) u_vote (
      .a_i        (yr[0][g]),
      .b_i        (yr[1][g]),
      .c_i        (yr[2][g]),
      .excl_i     (excl),
      .vote_o     (lane_vote[g]),
      .outvoted_o (lane_ov[g]),
      .nomaj_o    (lane_nomaj[g])
    );
  end

  always_comb begin
    ov_any    = 3'b000;
    nomaj_any = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      ov_any    = ov_any | lane_ov[l];
      nomaj_any = nomaj_any | lane_nomaj[l];
    end
    case (ov_any)
      3'b001:  cand_id = 2'd0;
      3'b010:  cand_id = 2'd1;
      3'b100:  cand_id = 2'd2;
      default: cand_id = FAULT_NONE;
    endcase
    single = (cand_id != FAULT_NONE);
    multi  = (ov_any != 3'b000) && !single;
  end

  always_comb begin
    state_d    = state_q;
    fault_id_d = fault_id_q;
    seq_d      = seq_q;
    fcnt_d     = fcnt_q;
    unrec_d    = unrec_q;
    rec_entry  = 1'b0;
    case (state_q)
      MONITOR: begin
        if (nomaj_any || multi) begin
          unrec_d = 1'b1;
        end else if (single && en) begin
          fault_id_d = cand_id;
          if (CONFIRM_CYC <= 1) begin
            state_d   = RECOVER;
            seq_d     = 8'd0;
            rec_entry = 1'b1;
          end else begin
            state_d = CONFIRM;
            seq_d   = 8'd1;
          end
        end
      end
      CONFIRM: begin
        if (!en || nomaj_any || multi || !single) begin
          unrec_d    = unrec_q | (en && (nomaj_any || multi));
          state_d    = MONITOR;
          fault_id_d = FAULT_NONE;
        end else if (cand_id != fault_id_q) begin
          fault_id_d = cand_id;
          seq_d      = 8'd1;
        end else if (seq_q >= 8'(CONFIRM_CYC - 1)) begin
          state_d   = RECOVER;
          seq_d     = 8'd0;
          rec_entry = 1'b1;
        end else begin
          seq_d = seq_q + 8'd1;
        end
      end
      RECOVER: begin
        if (nomaj_any) unrec_d = 1'b1;
        if (seq_q == 8'(RECOVER_CYC - 1)) begin
          state_d = SETTLE;
          seq_d   = 8'd0;
        end else begin
          seq_d = seq_q + 8'd1;
        end
      end
      SETTLE: begin
        if (nomaj_any) unrec_d = 1'b1;
        if (seq_q == 8'(SETTLE_CYC - 1)) begin
          state_d    = MONITOR;
          fault_id_d = FAULT_NONE;
          seq_d      = 8'd0;
        end else begin
          seq_d = seq_q + 8'd1;
        end
      end
      default: state_d = MONITOR;
    endcase
    for (int r = 0; r < 3; r++)
      if (rec_entry && fault_id_d == 2'(r) && fcnt_q[r] != {CNT_W{1'b1}})
        fcnt_d[r] = fcnt_q[r] + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MONITOR;
      fault_id_q <= FAULT_NONE;
      seq_q      <= 8'd0;
      fcnt_q     <= '0;
      unrec_q    <= 1'b0;
      vote_q     <= '0;
    end else begin
      state_q    <= state_d;
      fault_id_q <= fault_id_d;
      seq_q      <= seq_d;
      fcnt_q     <= fcnt_d;
      unrec_q    <= unrec_d;
      vote_q     <= lane_vote;
    end
  end

  // Decoded straight from state so an async reset drops the resync request immediately.
  assign rep_reset     = (state_q == RECOVER) ? rep_onehot(fault_id_q) : 3'b000;
  assign busy          = (state_q != MONITOR);
  assign fault_id      = fault_id_q;
  assign y_vote        = vote_q;
  assign unrecoverable = unrec_q;
  assign fault_cnt0    = fcnt_q[0];
  assign fault_cnt1    = fcnt_q[1];
  assign fault_cnt2    = fcnt_q[2];

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: voting, confirm/recover sequencing, sticky flag, saturation.
module tb_tmr_scrub_ctrl;
  import tmr_pkg::*;

  localparam int LANES  = 8;
  localparam int LANE_W = 16;
  localparam int CNT_W  = 2;
  localparam logic [LANES-1:0][LANE_W-1:0] ALL400 = {LANES{16'h0400}};

  logic                         clk, reset, en;
  logic [LANES-1:0][LANE_W-1:0] y0, y1, y2, y_vote;
  logic [2:0]                   rep_reset;
  logic [1:0]                   fault_id;
  logic [CNT_W-1:0]             fault_cnt0, fault_cnt1, fault_cnt2;
  logic                         busy, unrecoverable;

  int n_tests = 0;
  int n_fail  = 0;

  tmr_scrub_ctrl #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en),
    .y0(y0), .y1(y1), .y2(y2),
`ifdef TMR_ERR_INJECT_EN
    .inj_en(1'b0), .inj_rep(2'd3), .inj_lane(3'd0),
`endif
    .y_vote(y_vote), .rep_reset(rep_reset), .fault_id(fault_id),
    .fault_cnt0(fault_cnt0), .fault_cnt1(fault_cnt1), .fault_cnt2(fault_cnt2),
    .busy(busy), .unrecoverable(unrecoverable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [LANES-1:0][LANE_W-1:0] exp_v;
  int  nrec, cnt_at2;
  logic prev;

  initial begin
    reset = 1'b0; en = 1'b1;
    y0 = ALL400; y1 = ALL400; y2 = ALL400;
    #12;
    chk("rst_vote", y_vote, '0);
    chk("rst_fid", fault_id, 2'd3);
    chk("rst_rep", rep_reset, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_unrec", unrecoverable, 1'b0);
    chk("rst_cnt", {fault_cnt0, fault_cnt1, fault_cnt2}, 6'd0);
    #8 reset = 1'b1;
    step();
    chk("t1_vote", y_vote, ALL400);
    chk("t1_fid", fault_id, 2'd3);

    // transient single-cycle fault on replica 1 lane 6
    y1[6] = 16'h0000;
    step();
    chk("t2_vote", y_vote, ALL400);
    chk("t2_confirm_fid", fault_id, 2'd1);
    chk("t2_busy", busy, 1'b1);
    chk("t2_rep0", rep_reset, 3'b000);
    y1[6] = 16'h0400;
    step();
    chk("t2_back_fid", fault_id, 2'd3);
    chk("t2_back_busy", busy, 1'b0);
    chk("t2_cnt1", fault_cnt1, 2'd0);
    chk("t2_rep1", rep_reset, 3'b000);

    // persistent fault on replica 1 lane 6
    y1[6] = 16'h0000;
    step();
    chk("t3_confirm_rep", rep_reset, 3'b000);
    step();
    chk("t3_cnt1", fault_cnt1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_rep%0d", i), rep_reset, 3'b010);
      if (i == 2) chk("t3_vote_excl", y_vote, ALL400);
      step();
    end
    chk("t3_settle_rep", rep_reset, 3'b000);
    chk("t3_settle_busy", busy, 1'b1);
    y1[6] = 16'h0400;
    step();
    chk("t3_settle_busy2", busy, 1'b1);
    step();
    chk("t3_done_busy", busy, 1'b0);
    chk("t3_done_fid", fault_id, 2'd3);
    chk("t3_unrec", unrecoverable, 1'b0);

    // no majority in lane 0
    y0[0] = 16'h0400; y1[0] = 16'h0800; y2[0] = 16'h0C00;
    step();
    chk("t4_unrec", unrecoverable, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_vote", y_vote, ALL400);
    y1[0] = 16'h0400; y2[0] = 16'h0400;
    step(); step();
    chk("t4_sticky", unrecoverable, 1'b1);
    #2 reset = 1'b0;
    #1 chk("t4_rst_unrec", unrecoverable, 1'b0);
    chk("t4_rst_cnt1", fault_cnt1, 2'd0);
    reset = 1'b1;
    step();

    // degraded mode: healthy pair disagrees during replica 1 recovery
    y1[6] = 16'h0000;
    step();
    step();
    chk("t5_rep_entry", rep_reset, 3'b010);
    y2[3] = 16'h0001;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t5_rep%0d", i), rep_reset, 3'b010);
      if (i == 1) begin
        chk("t5_unrec", unrecoverable, 1'b1);
        chk("t5_vote", y_vote, ALL400);
      end
    end
    step();
    chk("t5_settle_rep", rep_reset, 3'b000);
    chk("t5_settle_busy", busy, 1'b1);
    y1[6] = 16'h0400; y2[3] = 16'h0400;
    step(); step();
    chk("t5_done_fid", fault_id, 2'd3);
    chk("t5_cnt1", fault_cnt1, 2'd1);

    #2 reset = 1'b0;
    #1 reset = 1'b1;
    step();

    // reset in the 2nd RECOVER cycle of replica 0
    y0[2] = 16'h0000;
    step();
    chk("t6_fid", fault_id, 2'd0);
    step();
    chk("t6_rep_a", rep_reset, 3'b001);
    chk("t6_cnt0_a", fault_cnt0, 2'd1);
    step();
    chk("t6_rep_b", rep_reset, 3'b001);
    #2 reset = 1'b0;
    #1 chk("t6_async_rep", rep_reset, 3'b000);
    chk("t6_async_cnt0", fault_cnt0, 2'd0);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_vote", y_vote, '0);
    #1 reset = 1'b1;

    // replica 0 left faulty: repeated recoveries saturate its counter
    nrec = 0; cnt_at2 = -1; prev = 1'b0;
    for (int i = 0; i < 200 && nrec < 5; i++) begin
      step();
      if (rep_reset[0] && !prev) begin
        nrec++;
        if (nrec == 2) cnt_at2 = int'(fault_cnt0);
      end
      prev = rep_reset[0];
    end
    chk("t6_nrec", nrec, 5);
    chk("t6_cnt_at2", cnt_at2, 2);
    chk("t6_sat", fault_cnt0, 2'd3);
    chk("t6_cnt2", fault_cnt2, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
- Supervises the three replicas of the TMR two-neuron datapath (8 lanes x 16-bit fixed point, 0x0400 = 1.0).
- Majority-votes each lane, detects a persistently outvoted replica, and sequences a per-replica resync pulse.
- Keeps fault statistics and raises a sticky flag when no majority can be guaranteed.
- Sits between the replica outputs and the top-level Y bus.

Parameters:
- LANES, 8, number of 16-bit lanes per replica word
- LANE_W, 16, lane width in bits
- CONFIRM_CYC, 2, consecutive cycles a replica must be outvoted before recovery starts
- RECOVER_CYC, 4, cycles the resync request is held
- SETTLE_CYC, 2, cycles after resync during which the recovered replica is excluded from voting
- CNT_W, 8, width of each saturating fault counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  monitoring enable; low forces MONITOR and blocks new recoveries
- y0  in  LANES*LANE_W  replica 0 output
- y1  in  LANES*LANE_W  replica 1 output
- y2  in  LANES*LANE_W  replica 2 output
- y_vote  out  LANES*LANE_W  registered voted word
- rep_reset  out  3  one-hot resync request to the faulty replica
- fault_id  out  2  replica under confirm or recovery; 3 = none
- fault_cnt0  out  CNT_W  recoveries of replica 0
- fault_cnt1  out  CNT_W  recoveries of replica 1
- fault_cnt2  out  CNT_W  recoveries of replica 2
- busy  out  1  high in CONFIRM, RECOVER or SETTLE
- unrecoverable  out  1  sticky no-majority flag

Behaviour:
- Reset (reset=0, asynchronous):
  - y_vote=0, rep_reset=0, fault_id=3, all counters=0, busy=0, unrecoverable=0, state=MONITOR.
- Voting:
  - Per-lane bitwise majority of y0/y1/y2, registered. Latency is 1 cycle.
  - While a replica is excluded (RECOVER/SETTLE), its lane value is ignored and each lane outputs the lower-index healthy replica.
- Per-lane disagreement flags:
  - outvoted[r] = replica r differs from the other two and those two agree.
  - nomaj = all three values differ.
- Candidate:
  - Replica r is the candidate when outvoted[r] is set in at least one lane and no other replica is outvoted in any lane.
- FSM: MONITOR, CONFIRM, RECOVER, SETTLE.
  - MONITOR:
    - Single candidate and en=1 -> CONFIRM, fault_id=r, confirm count=1.
    - nomaj in any lane, or two different replicas outvoted, -> unrecoverable=1 and stay in MONITOR.
  - CONFIRM:
    - Same candidate -> count++. When count reaches CONFIRM_CYC -> RECOVER.
    - Candidate vanishes (all replicas agree) -> MONITOR, fault_id=3, counters unchanged (transient fault).
    - Different candidate -> restart CONFIRM with the new id, count=1.
    - en=0 -> MONITOR.
  - RECOVER:
    - rep_reset[fault_id]=1 for exactly RECOVER_CYC cycles.
    - fault_cnt[fault_id] increments once on entry and saturates at all-ones.
    - Then -> SETTLE.
  - SETTLE:
    - SETTLE_CYC cycles with the replica still excluded, then -> MONITOR, fault_id=3.
- Degraded mode:
  - In RECOVER/SETTLE, any lane where the two healthy replicas differ sets unrecoverable=1.
  - The sequence still completes.
- unrecoverable clears only on reset.
- en=0 during RECOVER/SETTLE does not abort the sequence.
- Reset mid-sequence clears everything immediately; rep_reset drops asynchronously.
- If CONFIRM_CYC=1, the first detection goes straight to RECOVER on the next cycle.

Optional Feature:
- Macro: TMR_ERR_INJECT_EN.
- Defined:
  - Adds inputs inj_en (1 bit), inj_rep (2 bits), inj_lane (log2 LANES bits).
  - When inj_en=1, bit 0 of lane inj_lane of replica inj_rep is inverted before voting and comparison.
  - inj_rep=3 means no injection.
- Undefined:
  - The ports are absent and replicas are voted unmodified.

Decomposition:
- Package tmr_pkg holds:
  - LANES and LANE_W defaults
  - state enum {MONITOR, CONFIRM, RECOVER, SETTLE}
  - FAULT_NONE = 2'd3
  - lane slicing helper constants
- Sub-module tmr_lane_vote:
  - One lane: three LANE_W inputs plus a 3-bit exclude mask.
  - Outputs the voted value, outvoted[2:0] and nomaj.
  - Instantiated LANES times.

Test Plan:
1. All replicas 8x0x0400, reset released after 20 ns -> y_vote=8x0x0400 one cycle later, fault_id=3, rep_reset=0, counters 0.
2. y1 lane 6 = 0x0000 for 1 cycle only -> y_vote lane 6 stays 0x0400, CONFIRM entered then back to MONITOR, fault_cnt1=0, rep_reset never asserted.
3. y1 lane 6 = 0x0000 held -> after 2 cycles rep_reset=3'b010 for 4 cycles, fault_cnt1=1, busy high through SETTLE (2 cycles), then fault_id=3.
4. Lane 0 set to y0=0x0400, y1=0x0800, y2=0x0C00 -> unrecoverable=1 next cycle and y_vote lane 0 = 0x0400. Restoring the inputs keeps unrecoverable=1 until reset.
5. During replica 1 recovery, y2 lane 3 = 0x0001 with y0 = 0x0400 -> unrecoverable=1, rep_reset[1] still completes 4 cycles.
6. Reset asserted in the 2nd RECOVER cycle -> rep_reset=0 without waiting for a clock edge, counters 0. With CNT_W=2 and 5 forced recoveries of replica 0, fault_cnt0 saturates at 3.
